// File: rtl/qspi_pkg.sv
// Shared definitions for the QSPI flash responder: command codes, FSM states
// and status register bit positions.
package qspi_pkg;

  localparam logic [7:0] CMD_WREN = 8'h06;
  localparam logic [7:0] CMD_EN4B = 8'hB7;
  localparam logic [7:0] CMD_RDSR = 8'h05;
  localparam logic [7:0] CMD_READ = 8'h03;
  localparam logic [7:0] CMD_FAST = 8'h0B;
  localparam logic [7:0] CMD_QIOR = 8'hEB;
  localparam logic [7:0] CMD_PP   = 8'h02;
  localparam logic [7:0] CMD_QPP  = 8'h38;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DUMMY,
    ST_RD_DATA,
    ST_WR_DATA,
    ST_STATUS,
    ST_IGNORE
  } resp_state_e;

  localparam int STAT_WIP = 0;
  localparam int STAT_WEL = 1;
  localparam int STAT_ADS = 5;

endpackage

// File: rtl/qspi_resp_mem.sv
// Byte-wide RAM used as the flash array behind the responder.
// Read data is registered, so it is valid one clock after the read strobe.
module qspi_resp_mem #(
  parameter int AW = 16
) (
  input  logic          clk,
  input  logic [AW-1:0] addr,
  input  logic          re,
  output logic [7:0]    rdata,
  input  logic          we,
  input  logic [7:0]    wdata
);

  logic [7:0] mem [0:(2**AW)-1];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/qspi_flash_resp.sv
// QSPI flash responder: oversamples the host link on h_clk, decodes the
// command/address/dummy/data phases and serves a byte-wide memory plus status.
module qspi_flash_resp
  import qspi_pkg::*;
#(
  parameter int MEM_AW    = 16,
  parameter int DUMMY_CYC = 6,
  parameter int PROG_CYC  = 64
) (
  input  logic              h_clk,
  input  logic              h_rst,
  input  logic              sclk_in,
  input  logic              cs_n_in,
  input  logic [3:0]        io_in,
  output logic [3:0]        io_out,
  output logic [3:0]        io_oe,
  output logic [MEM_AW-1:0] mem_addr,
  output logic              mem_re,
  input  logic [7:0]        mem_rdata,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  output logic [7:0]        status_out
);

  localparam int WCW = $clog2(PROG_CYC + 1);

  logic [1:0] sclk_sync, cs_sync;
  logic       sclk_d, cs_d;
  logic       sclk_s, cs_n_s, rise, fall, cs_fall;

  resp_state_e state, state_nx;
  logic [5:0]  cnt, cnt_inc;
  logic [31:0] sr, sr_nx;
  logic [7:0]  cmd_byte, sh_out, nxt_byte;
  logic        quad, is_fast, is_prog, rd_pend, rd_to_sh;
  logic [2:0]  st_idx;
  logic        wel, ads, wip, written;
  logic [WCW-1:0] wip_cnt;
  logic        cmd_done, addr_done, dummy_done, wr_byte;

  always_ff @(posedge h_clk or posedge h_rst) begin
    if (h_rst) begin
      sclk_sync <= 2'b00;
      sclk_d    <= 1'b0;
      cs_sync   <= 2'b11;
      cs_d      <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[0], sclk_in};
      sclk_d    <= sclk_s;
      cs_sync   <= {cs_sync[0], cs_n_in};
      cs_d      <= cs_n_s;
    end
  end

  // sclk edges are masked while cs_n is high so a simultaneous cs_n rise wins
  assign sclk_s  = sclk_sync[1];
  assign cs_n_s  = cs_sync[1];
  assign rise    = sclk_s & ~sclk_d & ~cs_n_s;
  assign fall    = ~sclk_s & sclk_d & ~cs_n_s;
  assign cs_fall = ~cs_n_s & cs_d;

  assign cnt_inc    = cnt + (quad ? 6'd4 : 6'd1);
  assign sr_nx      = quad ? {sr[27:0], io_in} : {sr[30:0], io_in[0]};
  assign cmd_byte   = {sr[6:0], io_in[0]};
  assign cmd_done   = (state == ST_CMD) && rise && (cnt == 6'd7);
  assign addr_done  = (state == ST_ADDR) && rise && (cnt_inc == (ads ? 6'd32 : 6'd24));
  assign dummy_done = (state == ST_DUMMY) && rise && (cnt == 6'(DUMMY_CYC - 1));
  assign wr_byte    = (state == ST_WR_DATA) && rise && (cnt_inc == 6'd8);

  assign status_out = {2'b00, ads, 3'b000, wel, wip};

  always_ff @(posedge h_clk or posedge h_rst) begin
    if (h_rst) state <= ST_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (cs_n_s) begin
      state_nx = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:  if (cs_fall) state_nx = ST_CMD;
        ST_CMD: begin
          if (cmd_done) begin
            if (wip && (cmd_byte != CMD_RDSR)) state_nx = ST_IGNORE;
            else begin
              case (cmd_byte)
                CMD_RDSR: state_nx = ST_STATUS;
                CMD_READ, CMD_FAST, CMD_QIOR, CMD_PP, CMD_QPP: state_nx = ST_ADDR;
                default:  state_nx = ST_IGNORE;
              endcase
            end
          end
        end
        ST_ADDR: begin
          if (addr_done) begin
            if (is_prog)      state_nx = ST_WR_DATA;
            else if (is_fast) state_nx = ST_DUMMY;
            else              state_nx = ST_RD_DATA;
          end
        end
        ST_DUMMY: if (dummy_done) state_nx = ST_RD_DATA;
        default:  state_nx = state;
      endcase
    end
  end

  always_ff @(posedge h_clk or posedge h_rst) begin
    if (h_rst) begin
      io_out    <= 4'h0;
      io_oe     <= 4'h0;
      mem_addr  <= '0;
      mem_re    <= 1'b0;
      mem_we    <= 1'b0;
      mem_wdata <= 8'h00;
      cnt       <= 6'd0;
      sr        <= 32'd0;
      sh_out    <= 8'h00;
      nxt_byte  <= 8'h00;
      quad      <= 1'b0;
      is_fast   <= 1'b0;
      is_prog   <= 1'b0;
      rd_pend   <= 1'b0;
      rd_to_sh  <= 1'b0;
      st_idx    <= 3'd0;
      wel       <= 1'b0;
      ads       <= 1'b0;
      wip       <= 1'b0;
      written   <= 1'b0;
      wip_cnt   <= '0;
    end else begin
      mem_re  <= 1'b0;
      mem_we  <= 1'b0;
      rd_pend <= mem_re;
      if (wip) begin
        if (wip_cnt <= WCW'(1)) wip <= 1'b0;
        wip_cnt <= wip_cnt - WCW'(1);
      end
      // page-wrapping advance once the write strobe has been seen by memory
      if (mem_we) mem_addr[7:0] <= mem_addr[7:0] + 8'd1;

      if (cs_n_s) begin
        io_oe  <= 4'h0;
        io_out <= 4'h0;
        cnt    <= 6'd0;
        if ((state == ST_WR_DATA) && wel && written) begin
          wel     <= 1'b0;
          wip     <= 1'b1;
          wip_cnt <= WCW'(PROG_CYC);
        end
        written <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            cnt   <= 6'd0;
            sr    <= 32'd0;
            quad  <= 1'b0;
            io_oe <= 4'h0;
          end
          ST_CMD: begin
            if (rise) begin
              sr  <= sr_nx;
              cnt <= cnt_inc;
            end
            if (cmd_done) begin
              cnt     <= 6'd0;
              sr      <= 32'd0;
              st_idx  <= 3'd0;
              quad    <= (cmd_byte == CMD_QIOR) || (cmd_byte == CMD_QPP);
              is_fast <= (cmd_byte == CMD_FAST) || (cmd_byte == CMD_QIOR);
              is_prog <= (cmd_byte == CMD_PP) || (cmd_byte == CMD_QPP);
              if (!wip && (cmd_byte == CMD_WREN)) wel <= 1'b1;
              if (!wip && (cmd_byte == CMD_EN4B)) ads <= 1'b1;
            end
          end
          ST_ADDR: begin
            if (rise) begin
              sr  <= sr_nx;
              cnt <= cnt_inc;
            end
            if (addr_done) begin
              cnt      <= 6'd0;
              mem_addr <= sr_nx[MEM_AW-1:0];
              written  <= 1'b0;
              if (!is_prog && !is_fast) begin
                mem_re   <= 1'b1;
                rd_to_sh <= 1'b1;
              end
            end
          end
          ST_DUMMY: begin
            if (rise) cnt <= cnt + 6'd1;
            if (dummy_done) begin
              cnt      <= 6'd0;
              mem_re   <= 1'b1;
              rd_to_sh <= 1'b1;
            end
          end
          ST_RD_DATA: begin
            // the first byte goes straight to the shifter; later ones are prefetched
            if (rd_pend) begin
              if (rd_to_sh) begin
                sh_out   <= mem_rdata;
                rd_to_sh <= 1'b0;
                mem_re   <= 1'b1;
                mem_addr <= mem_addr + MEM_AW'(1);
              end else begin
                nxt_byte <= mem_rdata;
              end
            end
            if (fall) begin
              if (quad) begin
                io_out <= sh_out[7:4];
                io_oe  <= 4'hF;
              end else begin
                io_out <= {2'b00, sh_out[7], 1'b0};
                io_oe  <= 4'b0010;
              end
              if (cnt_inc == 6'd8) begin
                cnt      <= 6'd0;
                sh_out   <= nxt_byte;
                mem_re   <= 1'b1;
                mem_addr <= mem_addr + MEM_AW'(1);
              end else begin
                cnt    <= cnt_inc;
                sh_out <= quad ? {sh_out[3:0], 4'h0} : {sh_out[6:0], 1'b0};
              end
            end
          end
          ST_WR_DATA: begin
            if (rise) begin
              sr  <= sr_nx;
              cnt <= cnt_inc;
            end
            if (wr_byte) begin
              cnt <= 6'd0;
              if (wel) begin
                mem_we    <= 1'b1;
                mem_wdata <= sr_nx[7:0];
                written   <= 1'b1;
              end
            end
          end
          ST_STATUS: begin
            if (fall) begin
              io_out <= {2'b00, status_out[3'd7 - st_idx], 1'b0};
              io_oe  <= 4'b0010;
              st_idx <= st_idx + 3'd1;
            end
          end
          default: io_oe <= 4'h0;
        endcase
      end
    end
  end

endmodule

// File: doc/qspi_flash_resp.md
# qspi_flash_resp

Synthesizable QSPI flash responder. It is the target end of the link driven by the QSPI host controller, and it serves as the flash device in system-level benches and FPGA loopback builds. It oversamples `sclk_in`/`cs_n_in` on the system clock, decodes command, address, dummy and data phases on 1 or 4 lines, and accesses a byte-wide memory. It also maintains a status register that the host polls with its read-status sequence.

## Interface
- `MEM_AW`, 16: memory address width; byte address wraps at 2^MEM_AW.
- `DUMMY_CYC`, 6: dummy sclk cycles for 0xEB and 0x0B.
- `PROG_CYC`, 64: h_clk cycles WIP stays set after a program ends.
- `h_clk`  in  1  system clock; all state on rising edge.
- `h_rst`  in  1  asynchronous, active-high reset.
- `sclk_in`  in  1  QSPI clock from host, mode 0 (CPOL=0, CPHA=0).
- `cs_n_in`  in  1  chip select, active low.
- `io_in`  in  4  io[3:0] pad inputs.
- `io_out`  out  4  io[3:0] pad outputs.
- `io_oe`  out  4  per-line output enable.
- `mem_addr`  out  MEM_AW  memory byte address.
- `mem_re`  out  1  read strobe; `mem_rdata` valid exactly 1 h_clk later.
- `mem_rdata`  in  8  read data.
- `mem_we`  out  1  write strobe, one h_clk pulse.
- `mem_wdata`  out  8  write data.
- `status_out`  out  8  status register: [0] WIP, [1] WEL, [5] ADS (4-byte addressing), others 0.

## Operation
- `sclk_in` and `cs_n_in` pass through 2-flop synchronizers. A rising edge of the synced sclk is the sample event; a falling edge is the drive event. Requirement: sclk period ≥ 8 h_clk cycles.
- States: IDLE, CMD, ADDR, DUMMY, RD_DATA, WR_DATA, STATUS, IGNORE.
- IDLE → CMD on synced cs_n falling. Synced cs_n high in any state forces IDLE and `io_oe`=0 at the next h_clk.
- CMD: 8 bits sampled from io0, MSB first. Decode:
  - 0x06: sets WEL.
  - 0xB7: sets ADS.
  - 0x05 → STATUS.
  - 0x03 read 1-1-1, no dummy → ADDR.
  - 0x0B fast read 1-1-1 → ADDR.
  - 0xEB quad I/O read 1-4-4 → ADDR.
  - 0x02 program 1-1-1 → ADDR.
  - 0x38 quad program 1-4-4 → ADDR.
  - Any other code → IGNORE.
  - While WIP=1, every command except 0x05 → IGNORE.
- ADDR: 24 bits (ADS=0) or 32 bits (ADS=1), MSB first, on io0 or on io[3:0] (nibble, io3 = MSB). Upper bits beyond MEM_AW are discarded. Exit: reads go to DUMMY (0x0B/0xEB) or RD_DATA (0x03); programs go to WR_DATA.
- DUMMY: counts DUMMY_CYC rising edges; io lines stay undriven.
- RD_DATA:
  - `mem_re` is issued on the h_clk after the last address/dummy rising edge, and the byte is loaded into the output shifter.
  - Bits are driven on falling edges: single mode on io1 (oe=4'b0010); quad mode on io[3:0] (oe=4'b1111), high nibble first.
  - At each byte load, the next address (+1, wrapping) is prefetched.
- WR_DATA: bits sampled on io0 or io[3:0]. Each complete byte pulses `mem_we` once, but only if WEL=1. Address low 8 bits increment and wrap within the 256-byte page.
- STATUS: `status_out` is driven on io1 MSB first, repeating every 8 clocks until cs_n rises.
- End of program: cs_n rising after a program with WEL=1 and ≥1 byte written clears WEL and sets WIP for PROG_CYC h_clk.
- Partial bytes at cs_n rise are discarded and never written.
- IGNORE: no outputs driven; waits for cs_n high.

## Timing
- Reset values: `io_out`=0, `io_oe`=0, `mem_re`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `status_out`=0, state IDLE.
- Sampled bit registered 3 h_clk after the pin rising edge (2 sync + 1 detect). Driven bit appears ≤4 h_clk after the pin falling edge.
- First read bit is driven on the falling edge immediately following the last address/dummy rising edge.
- `mem_we` fires 1 h_clk after the sample of the last bit of a byte.
- A reset mid-transfer aborts with no memory write.
- cs_n rising and an sclk edge in the same h_clk: cs_n wins.
- WIP counter and cs_n activity are independent; a 0x05 read during WIP returns WIP=1.

## Structure
- Shared package `qspi_pkg`:
  - Command code constants.
  - Responder state enum.
  - Status bit indices.
- Natural sub-module: `qspi_resp_mem`, a parameterized byte RAM with 1-cycle read latency. Benches instantiate it beside the responder.

## Test plan
- 0x05 after reset → io1 shifts 8'h00. After 0x06, 0x05 → 8'h02.
- 0x06, then 0x02 addr 0x0000FE with bytes A1 B2 C3 → mem[0xFE]=A1, mem[0xFF]=B2, mem[0x00]=C3 (page wrap). Status then reads 8'h01 for PROG_CYC cycles, then 8'h00.
- 0x02 without WEL → no `mem_we` pulses; memory unchanged.
- mem[0x10..0x13]=11 22 33 44, 0xEB addr 0x000010, DUMMY_CYC=6 → io[3:0] nibbles 1,1,2,2,3,3,4,4; io_oe=4'hF only in the data phase.
- 0xB7, then 0x03 with 32-bit addr 0x00000010 → io1 returns 8'h11; status bit5=1.
- cs_n raised after 4 bits of a program byte → no write, WEL remains 1. Unknown cmd 0x9F → io_oe stays 0.
